// File: rtl/cnn_layer_accel_pkg.sv
// Shared constants and types for the CNN layer accelerator result path.
// Lane geometry and packer FSM encoding are defined once here.
package cnn_layer_accel_pkg;

    localparam int unsigned LANES      = 8;
    localparam int unsigned LANE_W     = 16;
    localparam int unsigned LANE_CNT_W = 3;
    localparam int unsigned WORD_W     = LANES * LANE_W;
    localparam int unsigned ENTRY_W    = WORD_W + LANES + 1;

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } pack_state_e;

    // Mask with the low n lanes set.
    function automatic logic [LANES-1:0] lane_mask(input logic [LANE_CNT_W-1:0] n);
        logic [LANES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            m[k] = (k < 32'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_result_fifo.sv
// Synchronous FIFO with a registered head entry; a push into an empty FIFO
// becomes visible on the output the cycle after the push edge.
module cnn_layer_accel_result_fifo #(
    parameter int unsigned WIDTH = 137,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_if,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;

    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && ((count != FULL_CNT) || do_pop);
        rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next  = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        // Head is refilled from the incoming word only when nothing else remains.
        if (do_push && ((count - (AW + 1)'(do_pop)) == '0)) begin
            head_next = push_data;
        end else if (count_next == '0) begin
            head_next = '0;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            head_q <= head_next;
        end
    end

    always_ff @(posedge clk_if) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = head_q;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs 16-bit convolution results into 8-lane 128-bit words with a lane mask,
// buffers them in a small FIFO and supports a job-end flush of the partial word.
module cnn_layer_accel_result_packer
    import cnn_layer_accel_pkg::*;
#(
    parameter int unsigned C_FIFO_DEPTH = 4
) (
    input  logic         clk_if,
    input  logic         rst,
    input  logic         result_valid,
    output logic         result_accept,
    input  logic [15:0]  result_data,
    input  logic         flush,
    output logic         flush_done,
    output logic         pack_valid,
    input  logic         pack_ready,
    output logic [127:0] pack_data,
    output logic [7:0]   pack_mask,
    output logic         pack_last,
    output logic [31:0]  result_count
);

    pack_state_e           state;
    pack_state_e           state_next;
    logic [LANE_CNT_W-1:0] lane_cnt;
    logic [LANE_W-1:0]     lanes [LANES];
    logic [31:0]           count_q;
    logic                  flush_done_q;
    logic                  flush_done_next;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  pop;
    logic                  room;
    logic                  accept;
    logic                  last_lane;
    logic                  push;
    logic [WORD_W-1:0]     push_word;
    logic [LANES-1:0]      push_mask;
    logic                  push_last;
    logic [ENTRY_W-1:0]    push_entry;

    always_comb begin
        pop       = !fifo_empty && pack_ready;
        room      = !fifo_full || pop;
        last_lane = (lane_cnt == LANE_CNT_W'(LANES - 1));
        result_accept = !rst && (state == ST_PACK) && !flush && (!last_lane || room);
        accept    = result_valid && result_accept;
        push      = (accept && last_lane) ||
                    ((state == ST_FLUSH) && (lane_cnt != '0) && room);

        // A full word takes lane 7 straight from the input; a flushed word zero-fills.
        push_word = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(lane_cnt)) begin
                push_word[k*LANE_W +: LANE_W] = lanes[k];
            end else if ((k == LANES - 1) && (state == ST_PACK)) begin
                push_word[k*LANE_W +: LANE_W] = result_data;
            end
        end
        push_mask  = (state == ST_PACK) ? {LANES{1'b1}} : lane_mask(lane_cnt);
        push_last  = (state == ST_FLUSH);
        push_entry = {push_last, push_mask, push_word};
    end

    always_comb begin
        state_next      = state;
        flush_done_next = 1'b0;
        case (state)
            ST_PACK: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((lane_cnt == '0) || room) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next      = ST_PACK;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = ST_PACK;
        endcase
    end

    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state        <= ST_PACK;
            lane_cnt     <= '0;
            count_q      <= '0;
            flush_done_q <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lanes[k] <= '0;
            end
        end else begin
            state        <= state_next;
            flush_done_q <= flush_done_next;
            if (accept) begin
                lanes[lane_cnt] <= result_data;
                lane_cnt        <= last_lane ? '0 : lane_cnt + LANE_CNT_W'(1);
                count_q         <= count_q + 32'd1;
            end else if ((state == ST_FLUSH) && push) begin
                lane_cnt <= '0;
            end
        end
    end

    cnn_layer_accel_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_if    (clk_if),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pack_valid   = !fifo_empty;
    assign pack_data    = fifo_head[WORD_W-1:0];
    assign pack_mask    = fifo_head[WORD_W +: LANES];
    assign pack_last    = fifo_head[ENTRY_W-1];
    assign flush_done   = flush_done_q;
    assign result_count = count_q;

endmodule

// File: doc/cnn_layer_accel_result_packer.md
CNN_LAYER_ACCEL_RESULT_PACKER -- requirements
Module: cnn_layer_accel_result_packer

Interface
REQ-001 SHALL have parameter C_FIFO_DEPTH, default 4, output word FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk_if, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port result_valid, input, 1 bit: upstream quad result valid.
REQ-005 SHALL have port result_accept, output, 1 bit: result taken when result_valid && result_accept.
REQ-006 SHALL have port result_data, input, 16 bits: one convolution output value.
REQ-007 SHALL have port flush, input, 1 bit: single-cycle request to emit the partial word at job end.
REQ-008 SHALL have port flush_done, output, 1 bit: single-cycle pulse when the flush has fully drained.
REQ-009 SHALL have port pack_valid, output, 1 bit: packed word available.
REQ-010 SHALL have port pack_ready, input, 1 bit: downstream pops when pack_valid && pack_ready.
REQ-011 SHALL have port pack_data, output, 128 bits: 8 lanes of 16 bits; lane k is bits [16k+15:16k].
REQ-012 SHALL have port pack_mask, output, 8 bits: bit k set means lane k is valid.
REQ-013 SHALL have port pack_last, output, 1 bit: word was produced by a flush.
REQ-014 SHALL have port result_count, output, 32 bits: results accepted since reset.

Function
REQ-015 SHALL fill lanes in acceptance order: the first result goes to lane 0; lane_cnt counts 0..7.
REQ-016 SHALL push {data, mask=8'hFF, last=0} into the FIFO on the same edge that the 8th result is accepted, and reset lane_cnt to 0.
REQ-017 SHALL present FIFO output registered: a push into an empty FIFO at edge N gives pack_valid=1 from N+1.
REQ-018 SHALL set result_accept = (state==PACK) && !flush && (lane_cnt!=7 || FIFO not full || pop this cycle).
REQ-019 SHALL implement FSM states PACK, FLUSH, DRAIN; reset state is PACK.
REQ-020 SHALL transition PACK->FLUSH on flush=1; flush has priority, so no result is accepted in that cycle.
REQ-021 SHALL, in FLUSH with lane_cnt>0, push the partial word when the FIFO has space (or pops this cycle): unused lanes zero, mask = (1<<lane_cnt)-1, last=1; it then clears lane_cnt and goes to DRAIN.
REQ-022 SHALL, in FLUSH with lane_cnt==0, push nothing and go directly to DRAIN.
REQ-023 SHALL, in DRAIN, wait for FIFO empty, then pulse flush_done for one cycle and return to PACK.
REQ-024 SHALL ignore flush while in FLUSH or DRAIN.
REQ-025 SHALL never drop or duplicate a word: the FIFO pushes only when not full or when popping in the same cycle; a pop on empty is ignored.
REQ-026 SHALL increment result_count by 1 per accepted result, wrapping from 32'hFFFF_FFFF to 0.
REQ-027 SHALL hold pack_data, pack_mask and pack_last stable while pack_valid=1 and pack_ready=0.

Reset
REQ-028 SHALL, on rst=1, clear immediately: result_accept=0, flush_done=0, pack_valid=0, pack_data=0, pack_mask=0, pack_last=0, result_count=0, lane_cnt=0, FIFO empty, state=PACK.
REQ-029 SHALL discard any partial word and all FIFO contents when rst is asserted mid-operation.

Structure
REQ-030 SHALL take the lane count (8), the lane width (16) and the FSM state enum from the shared package cnn_layer_accel_pkg.
REQ-031 SHALL instantiate one sub-module, cnn_layer_accel_result_fifo: synchronous, 137 bits wide (data+mask+last), C_FIFO_DEPTH deep, with full, empty and registered output.

Verification
REQ-032 SHALL cover: 16 back-to-back results 0x0001..0x0010 with pack_ready=1 -> two words, mask=FF, last=0, lane 0 = 0x0001 then 0x0009; result_count=16.
REQ-033 SHALL cover: pack_ready=0 and 8*C_FIFO_DEPTH+7 results offered -> result_accept drops with lane_cnt=7 and FIFO full; no loss after pack_ready=1.
REQ-034 SHALL cover: 3 results 0xA,0xB,0xC, then flush -> one word with mask=0x07, last=1, lanes 3..7 = 0, then flush_done exactly once.
REQ-035 SHALL cover: flush with lane_cnt==0 and 2 words queued -> no extra word; flush_done asserted one cycle after the FIFO empties.
REQ-036 SHALL cover: flush and result_valid in the same cycle -> that result is not accepted, and is accepted after returning to PACK.
REQ-037 SHALL cover: rst asserted mid-word with 5 lanes filled -> all outputs 0 immediately; the next 8 results form a clean word starting at lane 0.
